// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if
//   Byte stream from the UART receiver and the word-write port into
//   instruction memory.
//   uart_rx_valid/uart_rx_data/uart_rx_break : receiver -> loader
//   mem_we/mem_addr/mem_wdata                : loader -> instruction memory
//   Modports: master = loader (issues memory writes), slave = environment.
interface uart_prog_loader_if #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 8
);
    logic                    uart_rx_valid;
    logic [7:0]              uart_rx_data;
    logic                    uart_rx_break;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [8*WORD_BYTES-1:0] mem_wdata;

    modport master (input  uart_rx_valid, uart_rx_data, uart_rx_break,
                    output mem_we, mem_addr, mem_wdata);
    modport slave  (output uart_rx_valid, uart_rx_data, uart_rx_break,
                    input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Assembles UART bytes little-endian into WORD_BYTES-wide words and writes
//   them to consecutive instruction-memory addresses, holding the core in
//   reset until END_WORDS consecutive all-ones words end the load.
//   Inter-byte timeout discards a partial word; break restarts the load;
//   reaching DEPTH without a terminator flags overflow.
//   Optional feature macro: LOADER_CHECKSUM_EN (8-bit sum byte after the
//   terminator; mismatch sets chk_err and keeps cpu_rstn low).
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   bus          : uart_prog_loader_if.master (UART bytes in, memory writes out)
//   write_done   : load finished (level)
//   cpu_rstn     : core reset, active low
//   word_count   : words written in the current load
//   overflow, timeout_err, chk_err : sticky error flags, cleared by break
module uart_prog_loader #(
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH       = 256,
    parameter int END_WORDS   = 2,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int ADDR_W      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               resetn,
    uart_prog_loader_if.master bus,
    output logic               write_done,
    output logic               cpu_rstn,
    output logic [ADDR_W:0]    word_count,
    output logic               overflow,
    output logic               timeout_err,
    output logic               chk_err
);
    localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int IC_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BI_W-1:0] LAST_IDX = BI_W'(WORD_BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {ASSEMBLE, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {ASSEMBLE, WRITE, DONE} state_t;
`endif

    state_t                     state, state_nx;
    logic [WORD_BYTES-1:0][7:0] word_q;
    logic [BI_W-1:0]            byte_idx;
    logic [ADDR_W-1:0]          addr;
    logic [IC_W-1:0]            idle_cnt;
    logic [2:0]                 term_run, run_nx;
    logic                       brk, accept, run_hit, at_top, tmo_fire, ovf_set;
`ifdef LOADER_CHECKSUM_EN
    logic                       chk_take;
    logic [7:0]                 sum;
`endif

    assign brk = bus.uart_rx_break;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tmo_fire = 1'b0;
        ovf_set  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_take = 1'b0;
`endif
        run_nx   = (&word_q) ? term_run + 3'd1 : 3'd0;
        run_hit  = (run_nx == 3'(END_WORDS));
        at_top   = (addr == ADDR_W'(DEPTH - 1));
        case (state)
            ASSEMBLE: begin
                accept   = bus.uart_rx_valid;
                tmo_fire = !bus.uart_rx_valid && (byte_idx != '0) &&
                           (idle_cnt == IC_W'(TIMEOUT_CYC - 1));
            end
            WRITE: begin
                if (run_hit) begin
`ifdef LOADER_CHECKSUM_EN
                    // a byte arriving in this cycle is already the checksum
                    chk_take = bus.uart_rx_valid;
                    state_nx = bus.uart_rx_valid ? DONE : CHECK;
`else
                    state_nx = DONE;
`endif
                end else if (at_top) begin
                    ovf_set  = 1'b1;
                    state_nx = DONE;
                end else begin
                    // next word's byte 0 overlaps the write cycle
                    state_nx = ASSEMBLE;
                    accept   = bus.uart_rx_valid;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                chk_take = bus.uart_rx_valid;
                if (bus.uart_rx_valid) state_nx = DONE;
            end
`endif
            default: ;
        endcase
        if (accept && byte_idx == LAST_IDX) state_nx = WRITE;
        if (brk) begin
            state_nx = ASSEMBLE;
            accept   = 1'b0;
            tmo_fire = 1'b0;
            ovf_set  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_take = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ASSEMBLE;
            word_q      <= '0;
            byte_idx    <= '0;
            addr        <= '0;
            idle_cnt    <= '0;
            term_run    <= '0;
            word_count  <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (brk) begin
                byte_idx    <= '0;
                addr        <= '0;
                idle_cnt    <= '0;
                term_run    <= '0;
                word_count  <= '0;
                overflow    <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (accept) begin
                    word_q[byte_idx] <= bus.uart_rx_data;
                    byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
                end else if (tmo_fire) begin
                    byte_idx    <= '0;
                    timeout_err <= 1'b1;
                end
                // counts only while a partial word waits for its next byte
                idle_cnt <= (state == ASSEMBLE && byte_idx != '0 && !accept && !tmo_fire)
                            ? idle_cnt + 1'b1 : '0;
                if (state == WRITE) begin
                    addr       <= addr + 1'b1;
                    word_count <= word_count + 1'b1;
                    term_run   <= run_nx;
                end
                if (ovf_set) overflow <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum     <= '0;
            chk_err <= 1'b0;
        end else if (brk) begin
            sum     <= '0;
            chk_err <= 1'b0;
        end else begin
            if (accept) sum <= sum + bus.uart_rx_data;
            if (chk_take && bus.uart_rx_data != sum) chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = word_q;
    assign write_done    = (state == DONE);
    assign cpu_rstn      = (state == DONE) && !chk_err;
endmodule
